operand_streamer: RTL and testbench
===================================

OPERAND_STREAMER -- requirements
Module: operand_streamer

Interface
REQ-001 Parameter IO_DATA_WIDTH, default 16: width of each memory word and each output operand.
REQ-002 Parameter LOG2_OF_MEM_HEIGHT, default 20: memory address width.
REQ-003 Parameter COUNT_WIDTH, default 20: width of the triple-count input.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port rst_in, input, 1 bit: synchronous, active-high reset.
REQ-007 Port start, input, 1 bit: one-cycle job request, sampled in IDLE only.
REQ-008 Port base_addr, input, LOG2_OF_MEM_HEIGHT bits: first word address, latched on accepted start.
REQ-009 Port nb_triples, input, COUNT_WIDTH bits: number of triples to send, latched on accepted start.
REQ-010 Port mem_re, output, 1 bit: memory read enable.
REQ-011 Port mem_read_addr, output, LOG2_OF_MEM_HEIGHT bits: memory read address.
REQ-012 Port mem_qout, input, IO_DATA_WIDTH bits: read data, valid exactly one cycle after mem_re.
REQ-013 Ports out0, out1, out2, output, IO_DATA_WIDTH bits each: operand triple; out0 is the lowest address.
REQ-014 Port out_valid, output, 1 bit: the triple on out0..out2 is valid.
REQ-015 Port out_ready, input, 1 bit: the consumer accepts the triple this cycle.
REQ-016 Port running, output, 1 bit: high in every state except IDLE.
REQ-017 Port done, output, 1 bit: one-cycle pulse when the job completes.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, PRESENT and FINISH.
- IDLE->FETCH: start=1 and nb_triples!=0.
- IDLE->FINISH: start=1 and nb_triples=0.
- FETCH->PRESENT: after 3 reads issued and the 3rd word captured.
- PRESENT->FETCH: on handshake with triples remaining.
- PRESENT->FINISH: on handshake of the last triple.
- FINISH->IDLE: unconditionally after one cycle.
REQ-019 In FETCH, mem_re SHALL be high for exactly 3 consecutive cycles, with addresses A, A+1, A+2, where A is the current triple address.
REQ-020 mem_qout SHALL be captured into slot k (k=0,1,2) one cycle after the k-th read; FETCH SHALL last 4 cycles.
REQ-021 A handshake occurs on a rising edge where out_valid=1 and out_ready=1.
REQ-022 out_valid SHALL be high only in PRESENT.
REQ-023 Once asserted, out_valid SHALL stay high until the handshake.
REQ-024 out0..out2 SHALL stay stable while out_valid=1.
REQ-025 out_ready SHALL be allowed high before out_valid; the handshake then happens in the first PRESENT cycle.
REQ-026 On each handshake, the address SHALL advance by 3 and the remaining count SHALL decrement by 1.
REQ-027 Address arithmetic SHALL be modulo 2^LOG2_OF_MEM_HEIGHT: address wrap-around, no error.
REQ-028 done SHALL be high only in FINISH.
REQ-029 start SHALL be ignored whenever running=1.
REQ-030 mem_re SHALL be low outside FETCH.
REQ-031 Timing: start accepted at edge T -> first mem_re in cycle T+1 -> out_valid in cycle T+5.
REQ-032 Peak throughput SHALL be one triple per 5 cycles with out_ready held high.
REQ-033 mem_read_addr SHALL hold its last value while mem_re=0.

Reset
REQ-034 With rst_in=1 at a rising edge, the FSM SHALL go to IDLE and out_valid, done, mem_re and running SHALL be 0.
REQ-035 On that same reset edge, out0..out2, the address, the count and mem_read_addr SHALL be 0.
REQ-036 Reset mid-job SHALL abandon the job with no done pulse.
REQ-037 A read issued before reset SHALL NOT be captured after reset.

Structure
REQ-038 The FSM state enum and the handshake-width constants SHALL live in the shared accelerator package.
REQ-039 The block SHALL be one flat module with no sub-module; the registers use the codebase register macro.

Verification
REQ-040 base_addr=0x10, nb_triples=1, memory[0x10..0x12]={5,-3,7}, out_ready=1 -> out0..out2={5,-3,7}; out_valid at T+5; done at T+6.
REQ-041 nb_triples=3, out_ready=0 for 10 cycles after the first out_valid -> out_valid and data stable throughout, then 3 triples in address order, exactly 3 handshakes, one done.
REQ-042 nb_triples=0 -> no mem_re, no out_valid, done pulse at T+1.
REQ-043 base_addr=2^20-2, nb_triples=1 -> read addresses 0xFFFFE, 0xFFFFF, 0x00000.
REQ-044 rst_in=1 during the 2nd FETCH of a 2-triple job -> IDLE next cycle, all outputs 0, no done; a new job then runs correctly.
REQ-045 start pulsed while running -> ignored; base_addr and count unchanged.

Source files
------------

// File: rtl/operand_streamer_pkg.sv
// Shared accelerator definitions: streamer FSM states and the constants that
// size a triple transfer (words per triple, fetch phase counter).
package operand_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_PRESENT = 2'd2,
        ST_FINISH  = 2'd3
    } stream_state_e;

    // Words making up one operand triple.
    localparam int TRIPLE_WORDS = 3;

    // A fetch is three reads plus one trailing cycle to capture the last word.
    localparam int FETCH_CYCLES = 4;
    localparam int PHASE_WIDTH  = 2;

    localparam logic [PHASE_WIDTH-1:0] LAST_READ_PHASE  = PHASE_WIDTH'(TRIPLE_WORDS - 1);
    localparam logic [PHASE_WIDTH-1:0] LAST_FETCH_PHASE = PHASE_WIDTH'(FETCH_CYCLES - 1);

endpackage

// File: rtl/operand_streamer.sv
// Operand streamer: reads consecutive 3-word groups from a synchronous memory
// and presents each group as a triple on a valid/ready output.
module operand_streamer
    import operand_streamer_pkg::*;
#(
    parameter int IO_DATA_WIDTH      = 16,
    parameter int LOG2_OF_MEM_HEIGHT = 20,
    parameter int COUNT_WIDTH        = 20
) (
    input  logic                          clk,
    input  logic                          rst_in,
    input  logic                          start,
    input  logic [LOG2_OF_MEM_HEIGHT-1:0] base_addr,
    input  logic [COUNT_WIDTH-1:0]        nb_triples,
    output logic                          mem_re,
    output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_read_addr,
    input  logic [IO_DATA_WIDTH-1:0]      mem_qout,
    output logic [IO_DATA_WIDTH-1:0]      out0,
    output logic [IO_DATA_WIDTH-1:0]      out1,
    output logic [IO_DATA_WIDTH-1:0]      out2,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          running,
    output logic                          done
);

    localparam int AW = LOG2_OF_MEM_HEIGHT;
    localparam int DW = IO_DATA_WIDTH;
    localparam int CW = COUNT_WIDTH;

    stream_state_e          state_reg, state_next;
    logic [PHASE_WIDTH-1:0] phase_reg;
    logic [AW-1:0]          addr_reg;       // address of the current triple
    logic [AW-1:0]          last_rd_reg;    // last address driven with mem_re
    logic [CW-1:0]          count_reg;      // triples still to hand over
    logic [DW-1:0]          slot_reg [TRIPLE_WORDS];

    logic          accept_start;
    logic          handshake;
    logic          last_triple;
    logic          in_fetch;
    logic [AW-1:0] issue_addr;

    assign accept_start = (state_reg == ST_IDLE) && start;
    assign handshake    = (state_reg == ST_PRESENT) && out_ready;
    assign last_triple  = (count_reg == CW'(1));
    assign in_fetch     = (state_reg == ST_FETCH);
    // Wraps naturally at the address width.
    assign issue_addr   = addr_reg + AW'(phase_reg);

    // State register.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = (nb_triples != '0) ? ST_FETCH : ST_FINISH;
                end
            end
            ST_FETCH: begin
                if (phase_reg == LAST_FETCH_PHASE) begin
                    state_next = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    state_next = last_triple ? ST_FINISH : ST_FETCH;
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode: strobes depend on state (and fetch phase) only.
    always_comb begin
        mem_re    = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        running   = (state_reg != ST_IDLE);
        case (state_reg)
            ST_FETCH:   mem_re    = (phase_reg <= LAST_READ_PHASE);
            ST_PRESENT: out_valid = 1'b1;
            ST_FINISH:  done      = 1'b1;
            default:    ;
        endcase
    end

    // While reading, the address is the triple base plus phase; otherwise the
    // last issued address is held so the memory port does not toggle.
    assign mem_read_addr = mem_re ? issue_addr : last_rd_reg;

    // Fetch phase counter: counts through the four fetch cycles.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            phase_reg <= '0;
        end else if (in_fetch) begin
            phase_reg <= phase_reg + PHASE_WIDTH'(1);
        end else begin
            phase_reg <= '0;
        end
    end

    // Job bookkeeping: triple address, remaining count and held read address.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            addr_reg    <= '0;
            count_reg   <= '0;
            last_rd_reg <= '0;
        end else begin
            if (accept_start) begin
                addr_reg  <= base_addr;
                count_reg <= nb_triples;
            end else if (handshake) begin
                addr_reg  <= addr_reg + AW'(TRIPLE_WORDS);
                count_reg <= count_reg - CW'(1);
            end
            if (mem_re) begin
                last_rd_reg <= issue_addr;
            end
        end
    end

    // Word capture: the word read in phase k arrives in phase k+1. Reset
    // returns the FSM to IDLE, so a read in flight at reset is dropped.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            for (int k = 0; k < TRIPLE_WORDS; k++) begin
                slot_reg[k] <= '0;
            end
        end else if (in_fetch) begin
            for (int k = 0; k < TRIPLE_WORDS; k++) begin
                if (phase_reg == PHASE_WIDTH'(k + 1)) begin
                    slot_reg[k] <= mem_qout;
                end
            end
        end
    end

    assign out0 = slot_reg[0];
    assign out1 = slot_reg[1];
    assign out2 = slot_reg[2];

endmodule

// File: tb/tb_operand_streamer.sv
// Bench for operand_streamer: memory responder, scoreboard of expected read
// addresses and triples, and a monitor that compares whatever the DUT presents.
module tb_operand_streamer;
    import operand_streamer_pkg::*;

    localparam int DW = 16;
    localparam int AW = 20;
    localparam int CW = 20;

    logic          clk = 1'b0;
    logic          rst_in;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] nb_triples;
    logic          mem_re;
    logic [AW-1:0] mem_read_addr;
    logic [DW-1:0] mem_qout;
    logic [DW-1:0] out0, out1, out2;
    logic          out_valid;
    logic          out_ready;
    logic          running;
    logic          done;

    always #5 clk = ~clk;

    operand_streamer #(
        .IO_DATA_WIDTH(DW),
        .LOG2_OF_MEM_HEIGHT(AW),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst_in(rst_in),
        .start(start),
        .base_addr(base_addr),
        .nb_triples(nb_triples),
        .mem_re(mem_re),
        .mem_read_addr(mem_read_addr),
        .mem_qout(mem_qout),
        .out0(out0),
        .out1(out1),
        .out2(out2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .running(running),
        .done(done)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [DW-1:0]   mem_over [int];
    logic [3*DW-1:0] exp_trip [$];
    logic [AW-1:0]   exp_addr [$];

    int done_cnt    = 0;
    int hs_cnt      = 0;
    int first_re    = -1;
    int first_valid = -1;
    int first_done  = -1;
    int ready_mode  = 0;   // 0: always ready, 1: random, 2: never ready

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [31:0] h;
        if (mem_over.exists(int'(a))) return mem_over[int'(a)];
        h = 32'(a) * 32'd2654435761;
        return h[31:16];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
    endtask

    // Synchronous memory: data appears one cycle after the read; junk otherwise.
    always @(posedge clk) begin
        cyc++;
        mem_qout <= mem_re ? mem_word(mem_read_addr) : DW'($urandom);
    end

    // Consumer ready generator.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compares read addresses and presented triples with the scoreboard.
    always @(negedge clk) begin
        if (!rst_in) begin
            if (mem_re) begin
                if (first_re < 0) first_re = cyc;
                if (exp_addr.size() == 0) unexpected("read_addr", 64'(mem_read_addr));
                else check("read_addr", 64'(mem_read_addr), 64'(exp_addr.pop_front()));
            end
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (exp_trip.size() == 0) unexpected("triple", 64'({out2, out1, out0}));
                else begin
                    check("triple", 64'({out2, out1, out0}), 64'(exp_trip[0]));
                    if (out_ready) begin
                        void'(exp_trip.pop_front());
                        hs_cnt++;
                    end
                end
            end
            if (done) begin
                done_cnt++;
                if (first_done < 0) first_done = cyc;
            end
        end
    end

    // Reference model: a job reads words base+3i+k (mod 2^AW) and yields them
    // as triples in order.
    task automatic expect_job(input logic [AW-1:0] b, input int n);
        logic [AW-1:0] a;
        logic [DW-1:0] w [3];
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 3; k++) begin
                a = b + AW'(3 * i + k);
                exp_addr.push_back(a);
                w[k] = mem_word(a);
            end
            exp_trip.push_back({w[2], w[1], w[0]});
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] b, input int n, output int t);
        base_addr  = b;
        nb_triples = CW'(n);
        start      = 1'b1;
        @(posedge clk);
        #1;
        t     = cyc;
        start = 1'b0;
    endtask

    // Runs a job to completion; mode 2 stalls for 10 cycles after first valid.
    task automatic run_job(input logic [AW-1:0] b, input int n, input int mode,
                           input bit timed, input bit poke);
        int t, d0, h0, budget;
        first_re = -1; first_valid = -1; first_done = -1;
        d0 = done_cnt; h0 = hs_cnt;
        ready_mode = (mode == 2) ? 2 : mode;
        expect_job(b, n);
        pulse_start(b, n, t);
        if (poke) begin
            repeat (2) @(posedge clk);
            #1;
            base_addr = b + AW'(100); nb_triples = CW'(7); start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        if (mode == 2) begin
            for (int i = 0; i < 50 && first_valid < 0; i++) @(posedge clk);
            repeat (10) @(posedge clk);
            ready_mode = 0;
        end
        budget = 100 + 40 * n;
        for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check("done_pulses", 64'(done_cnt - d0), 64'd1);
        check("handshakes", 64'(hs_cnt - h0), 64'(n));
        check("left_triples", 64'(exp_trip.size()), 64'd0);
        check("left_reads", 64'(exp_addr.size()), 64'd0);
        check("running_after", 64'(running), 64'd0);
        if (timed) begin
            if (n == 0) begin
                check("done_time", 64'(first_done - t), 64'd0);
            end else begin
                check("first_read_time", 64'(first_re - t), 64'd0);
                check("valid_time", 64'(first_valid - t), 64'd4);
                check("done_time", 64'(first_done - t), 64'(5 * n));
            end
        end
        $display("job base=%05h n=%0d mode=%0d done=%0d hs=%0d", b, n, mode,
                 done_cnt - d0, hs_cnt - h0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_mem_re"}, 64'(mem_re), 64'd0);
        check({tag, "_running"}, 64'(running), 64'd0);
        check({tag, "_outs"}, 64'({out2, out1, out0}), 64'd0);
        check({tag, "_rd_addr"}, 64'(mem_read_addr), 64'd0);
    endtask

    initial begin
        int d0, h0;
        rst_in = 1'b1; start = 1'b0; base_addr = '0; nb_triples = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_in = 1'b0;
        @(posedge clk);
        #1;

        // Directed single triple with signed data.
        mem_over[16] = 16'd5; mem_over[17] = 16'hFFFD; mem_over[18] = 16'd7;
        run_job(AW'(16), 1, 0, 1'b1, 1'b0);
        // Zero-length job.
        run_job(AW'(16), 0, 0, 1'b1, 1'b0);
        // Consumer stall after first valid.
        run_job(AW'(200), 3, 2, 1'b0, 1'b0);
        // Address wrap-around.
        run_job(AW'(20'hFFFFE), 1, 0, 1'b1, 1'b0);
        // Start while running is ignored.
        run_job(AW'(500), 2, 0, 1'b1, 1'b1);
        // Back-to-back throughput.
        run_job(AW'($urandom), 4, 0, 1'b1, 1'b0);

        // Reset during the second fetch of a two-triple job.
        first_valid = -1;
        d0 = done_cnt; h0 = hs_cnt;
        ready_mode = 0;
        expect_job(AW'(300), 2);
        base_addr = AW'(300); nb_triples = CW'(2); start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 50 && hs_cnt == h0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        rst_in = 1'b1;
        exp_trip.delete();
        exp_addr.delete();
        @(posedge clk);
        #1;
        check_all_zero("midjob_reset");
        rst_in = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("reset_no_done", 64'(done_cnt - d0), 64'd0);
        check("reset_one_hs", 64'(hs_cnt - h0), 64'd1);
        $display("mid-job reset applied, done=%0d", done_cnt - d0);
        run_job(AW'(300), 2, 0, 1'b1, 1'b0);

        // Randomized jobs.
        for (int j = 0; j < 8; j++) begin
            run_job(AW'($urandom), $urandom_range(0, 4), $urandom_range(0, 1), 1'b0,
                    1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
